// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// sends it MSB-first on so, one bit per ck, with a bit strobe (so_en) and a start-of-word marker (sof).
module piso_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             ck,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    output logic             ready,
    output logic             so,
    output logic             so_en,
    output logic             sof,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    localparam int CW = $clog2(WIDTH);
    // The gap counter still needs one bit when GAP==0 so the design elaborates.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             so_q, so_d;
    logic             so_en_q, so_en_d;
    logic             sof_q, sof_d;
    logic             busy_q, busy_d;

    logic last_bit;
    logic accept;

    // Handshake: a word is taken at any rising ck where valid && ready. ready depends only on
    // state and bit count, never on valid; valid while ready==0 is ignored, and din is only
    // sampled at the accepting edge.
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_BIT);
    assign ready    = (state_q == S_IDLE) || ((GAP == 0) && last_bit);
    assign accept   = valid && ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        so_d    = 1'b0;
        so_en_d = 1'b0;
        sof_d   = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    // so already shows shreg_q[WIDTH-1]; the next bit is the one below it.
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                    so_d    = shreg_q[WIDTH-2];
                    so_en_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d  = gap_q + GW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new word overrides the above; with GAP==0 this gives back-to-back words.
        if (accept) begin
            state_d = S_SHIFT;
            shreg_d = din;
            cnt_d   = '0;
            so_d    = din[WIDTH-1];
            so_en_d = 1'b1;
            sof_d   = 1'b1;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            so_q    <= 1'b0;
            so_en_q <= 1'b0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            so_q    <= so_d;
            so_en_q <= so_en_d;
            sof_q   <= sof_d;
            busy_q  <= busy_d;
        end
    end

    assign so          = so_q;
    assign so_en       = so_en_q;
    assign sof         = sof_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
